// File: rtl/global_mem_axi.sv
// Beat-wide global memory model with an AXI4-style slave front end.
// Independent INCR read and write burst engines, one outstanding transaction each.
module global_mem_axi #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int N_BANK     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH_W    = 12,
    parameter int RD_LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [ADDR_W-1:0]          m0_araddr,
    input  logic [7:0]                 m0_arlen,
    input  logic                       m0_arvalid,
    output logic                       m0_arready,
    input  logic [ID_WIDTH-1:0]        m0_arid,
    output logic [DATA_W*N_BANK-1:0]   m0_rdata,
    output logic                       m0_rlast,
    output logic                       m0_rvalid,
    input  logic                       m0_rready,
    output logic [ID_WIDTH-1:0]        m0_rid,
    input  logic [ADDR_W-1:0]          m0_awaddr,
    input  logic [7:0]                 m0_awlen,
    input  logic                       m0_awvalid,
    output logic                       m0_awready,
    input  logic [ID_WIDTH-1:0]        m0_awid,
    input  logic                       m0_wvalid,
    input  logic [DATA_W*N_BANK-1:0]   m0_wdata,
    input  logic [DATA_W*N_BANK/8-1:0] m0_wstrb,
    input  logic                       m0_wlast,
    output logic                       m0_wready,
    output logic                       m0_bvalid,
    input  logic                       m0_bready,
    output logic [ID_WIDTH-1:0]        m0_bid
);

    localparam int BEAT_W = DATA_W * N_BANK;
    localparam int BB     = BEAT_W / 8;
    localparam int OFF_W  = $clog2(BB);
    localparam int DEPTH  = 1 << DEPTH_W;
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

    // Byte address to beat index; offset and upper bits are dropped so the index wraps.
    function automatic logic [DEPTH_W-1:0] beat_idx(input logic [ADDR_W-1:0] addr);
        return addr[DEPTH_W+OFF_W-1:OFF_W];
    endfunction

    logic [BEAT_W-1:0] ram_q [DEPTH];

    r_state_t          r_state_q, r_state_d;
    logic [DEPTH_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]        rd_len_q, rd_len_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [BEAT_W-1:0] rdata_q, rdata_d;
    logic [DEPTH_W-1:0] rd_idx_nxt_s;

    w_state_t          w_state_q, w_state_d;
    logic [DEPTH_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]        wr_len_q, wr_len_d;
    logic [7:0]        wr_cnt_q, wr_cnt_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic              wr_en_s;

    logic unused_s;
    assign unused_s = m0_wlast;

    assign rd_idx_nxt_s = rd_idx_q + {{(DEPTH_W-1){1'b0}}, 1'b1};

    // Read engine next-state; RAM is read combinationally so a same-edge write is not seen.
    always_comb begin
        r_state_d = r_state_q;
        rd_idx_d  = rd_idx_q;
        rd_len_d  = rd_len_q;
        rd_cnt_d  = rd_cnt_q;
        lat_d     = lat_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (m0_arvalid && arready_q) begin
                    rd_idx_d  = beat_idx(m0_araddr);
                    rd_len_d  = m0_arlen;
                    rd_cnt_d  = 8'd0;
                    rid_d     = m0_arid;
                    lat_d     = LAT_W'(RD_LATENCY - 1);
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_WAIT: begin
                if (lat_q == {LAT_W{1'b0}}) begin
                    rvalid_d  = 1'b1;
                    rlast_d   = (rd_len_q == 8'd0);
                    rdata_d   = ram_q[rd_idx_q];
                    r_state_d = R_DATA;
                end else begin
                    lat_d = lat_q - {{(LAT_W-1){1'b0}}, 1'b1};
                end
            end
            R_DATA: begin
                if (m0_rready && rvalid_q) begin
                    if (rd_cnt_q == rd_len_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_nxt_s;
                        rd_cnt_d = rd_cnt_q + 8'd1;
                        rdata_d  = ram_q[rd_idx_nxt_s];
                        rlast_d  = ((rd_cnt_q + 8'd1) == rd_len_q);
                    end
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // Write engine next-state; the beat counter, not wlast, ends the burst.
    always_comb begin
        w_state_d = w_state_q;
        wr_idx_d  = wr_idx_q;
        wr_len_d  = wr_len_q;
        wr_cnt_d  = wr_cnt_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        wr_en_s   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (m0_awvalid && awready_q) begin
                    wr_idx_d  = beat_idx(m0_awaddr);
                    wr_len_d  = m0_awlen;
                    wr_cnt_d  = 8'd0;
                    bid_d     = m0_awid;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    awready_d = 1'b1;
                    wready_d  = 1'b0;
                end
            end
            W_DATA: begin
                if (m0_wvalid && wready_q) begin
                    wr_en_s = 1'b1;
                    if (wr_cnt_q == wr_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        wr_idx_d = wr_idx_q + {{(DEPTH_W-1){1'b0}}, 1'b1};
                        wr_cnt_d = wr_cnt_q + 8'd1;
                    end
                end else begin
                    wready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (m0_bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Byte-enabled RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !nrst) begin
            for (int b = 0; b < BB; b++) begin
                if (m0_wstrb[b]) begin
                    ram_q[wr_idx_q][b*8 +: 8] <= m0_wdata[b*8 +: 8];
                end
            end
        end
    end

    // State and registered outputs for both engines.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state_q <= R_IDLE;
            rd_idx_q  <= {DEPTH_W{1'b0}};
            rd_len_q  <= 8'd0;
            rd_cnt_q  <= 8'd0;
            lat_q     <= {LAT_W{1'b0}};
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= {ID_WIDTH{1'b0}};
            rdata_q   <= {BEAT_W{1'b0}};
            w_state_q <= W_IDLE;
            wr_idx_q  <= {DEPTH_W{1'b0}};
            wr_len_q  <= 8'd0;
            wr_cnt_q  <= 8'd0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= {ID_WIDTH{1'b0}};
        end else begin
            r_state_q <= r_state_d;
            rd_idx_q  <= rd_idx_d;
            rd_len_q  <= rd_len_d;
            rd_cnt_q  <= rd_cnt_d;
            lat_q     <= lat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            w_state_q <= w_state_d;
            wr_idx_q  <= wr_idx_d;
            wr_len_q  <= wr_len_d;
            wr_cnt_q  <= wr_cnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
        end
    end

    assign m0_arready = arready_q;
    assign m0_rvalid  = rvalid_q;
    assign m0_rlast   = rlast_q;
    assign m0_rid     = rid_q;
    assign m0_rdata   = rdata_q;
    assign m0_awready = awready_q;
    assign m0_wready  = wready_q;
    assign m0_bvalid  = bvalid_q;
    assign m0_bid     = bid_q;

endmodule

// File: tb/tb_global_mem_axi.sv
// Directed bench for global_mem_axi: bursts, strobes, stalls, collisions, wrap and reset abort.
module tb_global_mem_axi;

    localparam int RD_LATENCY = 4;

    logic         clk;
    logic         nrst;
    logic [31:0]  m0_araddr;
    logic [7:0]   m0_arlen;
    logic         m0_arvalid;
    logic         m0_arready;
    logic [3:0]   m0_arid;
    logic [127:0] m0_rdata;
    logic         m0_rlast;
    logic         m0_rvalid;
    logic         m0_rready;
    logic [3:0]   m0_rid;
    logic [31:0]  m0_awaddr;
    logic [7:0]   m0_awlen;
    logic         m0_awvalid;
    logic         m0_awready;
    logic [3:0]   m0_awid;
    logic         m0_wvalid;
    logic [127:0] m0_wdata;
    logic [15:0]  m0_wstrb;
    logic         m0_wlast;
    logic         m0_wready;
    logic         m0_bvalid;
    logic         m0_bready;
    logic [3:0]   m0_bid;

    int total;
    int bad;
    logic [127:0] wbuf [4];
    logic [127:0] rbuf [4];

    global_mem_axi #(
        .ADDR_W(32), .DATA_W(32), .N_BANK(4), .ID_WIDTH(4), .DEPTH_W(12), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk), .nrst(nrst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_arid(m0_arid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
        .m0_rready(m0_rready), .m0_rid(m0_rid),
        .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_awid(m0_awid), .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_wlast(m0_wlast), .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m0_bid(m0_bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'hA0 + 8'(i);
        return {24'h333333, b, 24'h222222, b, 24'h111111, b, 24'h000000, b};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [15:0] strb);
        chk("aw_ready_idle", 128'(m0_awready), 128'd1);
        m0_awaddr = addr; m0_awlen = len; m0_awid = id; m0_awvalid = 1'b1;
        step();
        m0_awvalid = 1'b0;
        chk("aw_ready_busy", 128'(m0_awready), 128'd0);
        for (int i = 0; i <= int'(len); i++) begin
            m0_wdata = wbuf[i]; m0_wstrb = strb; m0_wlast = (i == int'(len)); m0_wvalid = 1'b1;
            chk("w_ready", 128'(m0_wready), 128'd1);
            step();
        end
        m0_wvalid = 1'b0; m0_wlast = 1'b0;
        chk("w_ready_done", 128'(m0_wready), 128'd0);
        chk("b_valid", 128'(m0_bvalid), 128'd1);
        chk("b_id", 128'(m0_bid), 128'(id));
        m0_bready = 1'b1;
        step();
        m0_bready = 1'b0;
        chk("b_valid_clr", 128'(m0_bvalid), 128'd0);
        chk("aw_ready_back", 128'(m0_awready), 128'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        chk("ar_ready_idle", 128'(m0_arready), 128'd1);
        m0_araddr = addr; m0_arlen = len; m0_arid = id; m0_arvalid = 1'b1; m0_rready = 1'b1;
        step();
        m0_arvalid = 1'b0;
        chk("ar_ready_busy", 128'(m0_arready), 128'd0);
        repeat (RD_LATENCY) begin
            chk("r_latency", 128'(m0_rvalid), 128'd0);
            step();
        end
        for (int i = 0; i <= int'(len); i++) begin
            chk("r_valid", 128'(m0_rvalid), 128'd1);
            chk("r_data", m0_rdata, rbuf[i]);
            chk("r_id", 128'(m0_rid), 128'(id));
            chk("r_last", 128'(m0_rlast), 128'(i == int'(len)));
            step();
        end
        chk("r_valid_end", 128'(m0_rvalid), 128'd0);
        chk("ar_ready_back", 128'(m0_arready), 128'd1);
    endtask

    initial begin
        int k;
        int cyc;
        int n;
        total = 0; bad = 0;
        nrst = 1'b1;
        m0_araddr = 32'd0; m0_arlen = 8'd0; m0_arvalid = 1'b0; m0_arid = 4'd0; m0_rready = 1'b0;
        m0_awaddr = 32'd0; m0_awlen = 8'd0; m0_awvalid = 1'b0; m0_awid = 4'd0;
        m0_wvalid = 1'b0; m0_wdata = 128'd0; m0_wstrb = 16'd0; m0_wlast = 1'b0; m0_bready = 1'b0;
        repeat (3) step();
        chk("rst_arready", 128'(m0_arready), 128'd1);
        chk("rst_awready", 128'(m0_awready), 128'd1);
        chk("rst_wready", 128'(m0_wready), 128'd0);
        chk("rst_rvalid", 128'(m0_rvalid), 128'd0);
        chk("rst_rlast", 128'(m0_rlast), 128'd0);
        chk("rst_bvalid", 128'(m0_bvalid), 128'd0);
        chk("rst_rid", 128'(m0_rid), 128'd0);
        chk("rst_bid", 128'(m0_bid), 128'd0);
        chk("rst_rdata", m0_rdata, 128'd0);
        nrst = 1'b0;
        step();

        // Burst write then read back.
        for (int i = 0; i < 4; i++) wbuf[i] = pat(i);
        do_write(32'h100, 8'd3, 4'd3, 16'hFFFF);
        for (int i = 0; i < 4; i++) rbuf[i] = pat(i);
        do_read(32'h100, 8'd3, 4'd5);

        // Offset bits ignored: 0x10C is the same beat as 0x100.
        rbuf[0] = pat(0);
        do_read(32'h10C, 8'd0, 4'd1);

        // Partial strobe.
        wbuf[0] = {128{1'b1}};
        do_write(32'h200, 8'd0, 4'd1, 16'hFFFF);
        wbuf[0] = 128'h55555555_66666666_77777777_12345678;
        do_write(32'h200, 8'd0, 4'd2, 16'h000F);
        rbuf[0] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h12345678};
        do_read(32'h200, 8'd0, 4'd6);

        // Beat index wraps from 4095 to 0; upper address bits ignored.
        wbuf[0] = pat(8); wbuf[1] = pat(9);
        do_write(32'h0001_FFF0, 8'd1, 4'd4, 16'hFFFF);
        rbuf[0] = pat(8); rbuf[1] = pat(9);
        do_read(32'h0000_FFF0, 8'd1, 4'd7);
        rbuf[0] = pat(9);
        do_read(32'h0000_0000, 8'd0, 4'd8);

        // rready toggling: data must hold while stalled, all beats delivered in order.
        m0_rready = 1'b0;
        m0_araddr = 32'h100; m0_arlen = 8'd3; m0_arid = 4'd10; m0_arvalid = 1'b1;
        step();
        m0_arvalid = 1'b0;
        n = 0;
        while (!m0_rvalid && n < 10) begin
            step();
            n++;
        end
        chk("tog_rvalid", 128'(m0_rvalid), 128'd1);
        k = 0; cyc = 0;
        while (k < 4 && cyc < 20) begin
            chk("tog_valid", 128'(m0_rvalid), 128'd1);
            chk("tog_data", m0_rdata, pat(k));
            chk("tog_last", 128'(m0_rlast), 128'(k == 3));
            m0_rready = cyc[0];
            step();
            if (m0_rready) k++;
            cyc++;
        end
        chk("tog_beats", 128'(k), 128'd4);
        chk("tog_end", 128'(m0_rvalid), 128'd0);

        // Simultaneous AR/AW; the write beat lands on the same edge as the read fetch.
        wbuf[0] = pat(7);
        do_write(32'h300, 8'd0, 4'd1, 16'hFFFF);
        m0_rready = 1'b1;
        m0_araddr = 32'h300; m0_arlen = 8'd0; m0_arid = 4'd2; m0_arvalid = 1'b1;
        m0_awaddr = 32'h300; m0_awlen = 8'd0; m0_awid = 4'd9; m0_awvalid = 1'b1;
        step();
        m0_arvalid = 1'b0; m0_awvalid = 1'b0;
        chk("col_arready", 128'(m0_arready), 128'd0);
        chk("col_awready", 128'(m0_awready), 128'd0);
        step();
        step();
        step();
        m0_wdata = pat(12); m0_wstrb = 16'hFFFF; m0_wlast = 1'b1; m0_wvalid = 1'b1;
        step();
        m0_wvalid = 1'b0; m0_wlast = 1'b0;
        chk("col_rvalid", 128'(m0_rvalid), 128'd1);
        chk("col_old_data", m0_rdata, pat(7));
        chk("col_rid", 128'(m0_rid), 128'd2);
        chk("col_rlast", 128'(m0_rlast), 128'd1);
        chk("col_bvalid", 128'(m0_bvalid), 128'd1);
        chk("col_bid", 128'(m0_bid), 128'd9);
        m0_bready = 1'b1;
        step();
        m0_bready = 1'b0;
        chk("col_rdone", 128'(m0_rvalid), 128'd0);
        chk("col_bdone", 128'(m0_bvalid), 128'd0);
        rbuf[0] = pat(12);
        do_read(32'h300, 8'd0, 4'd3);

        // Reset while beat 2 of 4 is presented.
        m0_araddr = 32'h100; m0_arlen = 8'd3; m0_arid = 4'd11; m0_arvalid = 1'b1; m0_rready = 1'b1;
        step();
        m0_arvalid = 1'b0;
        repeat (RD_LATENCY) step();
        step();
        step();
        chk("rst_mid_beat2", m0_rdata, pat(2));
        chk("rst_mid_last", 128'(m0_rlast), 128'd0);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        chk("rst_mid_rvalid", 128'(m0_rvalid), 128'd0);
        chk("rst_mid_arready", 128'(m0_arready), 128'd1);
        chk("rst_mid_rlast", 128'(m0_rlast), 128'd0);
        rbuf[0] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h12345678};
        do_read(32'h200, 8'd0, 4'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
